// File: rtl/pdm_mic_rx_if.sv
// PCM sample handshake between the PDM capture block and its consumer.
//   sample        signed PCM sample, two's complement (producer -> consumer)
//   sample_valid  holding register contains an unconsumed sample (producer -> consumer)
//   sample_ready  consumer takes the sample this cycle (consumer -> producer)
// master: the PDM receiver; slave: the pitch-detection logic.
interface pdm_mic_rx_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] sample;
    logic                    sample_valid;
    logic                    sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates the microphone clock, samples the 1-bit
// left-channel stream, decimates it with a 3rd-order CIC filter and hands
// signed PCM samples to the consumer through a one-entry holding register.
//
// Ports:
//   CLK100MHZ    system clock
//   CPU_RESETN   asynchronous active-low reset
//   mic_en       capture enable; low stops the mic clock and clears the filter
//   M_DATA       PDM data from the microphone
//   M_CLK        PDM clock to the microphone (CLK100MHZ / (2*CLK_DIV))
//   M_LRSEL      channel select, tied to left (0)
//   pcm          sample / sample_valid / sample_ready handshake (master side)
//   overrun      sticky flag: a sample was dropped because the register was full
//   overrun_clr  clears overrun (a simultaneous new overrun wins)
//   level        4-bit peak level meter
//
// Build option: define PDM_LEVEL_METER_EN to include the peak level meter;
// otherwise level is tied to 0.
module pdm_mic_rx #(
    parameter int CLK_DIV = 20,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16,
    parameter int WARMUP  = 3
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                mic_en,
    input  logic                M_DATA,
    output logic                M_CLK,
    output logic                M_LRSEL,
    pdm_mic_rx_if.master        pcm,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic [3:0]          level
);
    localparam int LOG2_D = $clog2(DECIM);
    localparam int ACC_W  = 3 * LOG2_D + 2;
    localparam int SHIFT  = 3 * LOG2_D - (OUT_W - 1);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WU_W   = $clog2(WARMUP + 2);
    localparam int SW     = ACC_W + OUT_W;
    localparam logic [DIV_W-1:0]     DIV_TC  = DIV_W'(CLK_DIV - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              m_data_sync;
    logic [DIV_W-1:0]        div_cnt;
    logic [LOG2_D-1:0]       bit_cnt;
    logic [WU_W-1:0]         warm_cnt;
    logic signed [ACC_W-1:0] integ1, integ2, integ3;
    logic signed [ACC_W-1:0] i1_nxt, i2_nxt, i3_nxt, x_in;
    logic signed [ACC_W-1:0] comb1, comb2, comb3, dly1, dly2, dly3;
    logic                    dec_stb, c1_stb, c2_stb, c3_stb;
    logic                    div_tc, bit_stb, warm_done, load, accept, loaded, ovr_set;
    logic signed [SW-1:0]    wide, scaled;
    logic signed [OUT_W-1:0] sat_val, sample_q;
    logic                    valid_q;

    assign M_LRSEL = 1'b0;
    assign div_tc  = (div_cnt == DIV_TC);
    // Falling M_CLK edge closes the high phase: left-channel data is valid here.
    assign bit_stb = div_tc & M_CLK;

    // 1 -> +1, 0 -> -1, sign-extended to the accumulator width.
    assign x_in   = {{(ACC_W-1){~m_data_sync[1]}}, 1'b1};
    assign i1_nxt = integ1 + x_in;
    assign i2_nxt = integ2 + i1_nxt;
    assign i3_nxt = integ3 + i2_nxt;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) m_data_sync <= 2'b00;
        else             m_data_sync <= {m_data_sync[0], M_DATA};
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt  <= '0;   M_CLK   <= 1'b0;  bit_cnt <= '0;    warm_cnt <= '0;
            integ1   <= '0;   integ2  <= '0;    integ3  <= '0;
            comb1    <= '0;   comb2   <= '0;    comb3   <= '0;
            dly1     <= '0;   dly2    <= '0;    dly3    <= '0;
            dec_stb  <= 1'b0; c1_stb  <= 1'b0;  c2_stb  <= 1'b0;  c3_stb   <= 1'b0;
        end else if (!mic_en) begin
            div_cnt  <= '0;   M_CLK   <= 1'b0;  bit_cnt <= '0;    warm_cnt <= '0;
            integ1   <= '0;   integ2  <= '0;    integ3  <= '0;
            comb1    <= '0;   comb2   <= '0;    comb3   <= '0;
            dly1     <= '0;   dly2    <= '0;    dly3    <= '0;
            dec_stb  <= 1'b0; c1_stb  <= 1'b0;  c2_stb  <= 1'b0;  c3_stb   <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                M_CLK   <= ~M_CLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (bit_stb) begin
                integ1  <= i1_nxt;
                integ2  <= i2_nxt;
                integ3  <= i3_nxt;
                bit_cnt <= bit_cnt + 1'b1;
            end
            // DECIM is a power of two, so an all-ones count marks the last bit.
            dec_stb <= bit_stb & (&bit_cnt);

            // Comb chain, one stage per system cycle.
            c1_stb <= dec_stb;
            c2_stb <= c1_stb;
            c3_stb <= c2_stb;
            if (dec_stb) begin
                comb1 <= integ3 - dly1;
                dly1  <= integ3;
            end
            if (c1_stb) begin
                comb2 <= comb1 - dly2;
                dly2  <= comb1;
            end
            if (c2_stb) begin
                comb3 <= comb2 - dly3;
                dly3  <= comb2;
            end

            if (c3_stb && !warm_done) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    assign wide = SW'(comb3);
    if (SHIFT >= 0) begin : g_shr
        assign scaled = wide >>> SHIFT;
    end else begin : g_shl
        assign scaled = wide <<< (-SHIFT);
    end

    always_comb begin
        sat_val = scaled[OUT_W-1:0];
        if (scaled > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (scaled < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    end

    assign warm_done = (warm_cnt == WU_W'(WARMUP));
    // mic_en gate stops a sample already in the comb pipe from landing after disable.
    assign load    = c3_stb & warm_done & mic_en;
    assign accept  = ~valid_q | pcm.sample_ready;
    assign loaded  = load & accept;
    assign ovr_set = load & ~accept;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (loaded) begin
                sample_q <= sat_val;
                valid_q  <= 1'b1;
            end else if (valid_q && pcm.sample_ready) begin
                valid_q  <= 1'b0;
            end
            overrun <= ovr_set | (overrun & ~overrun_clr);
        end
    end

    assign pcm.sample       = sample_q;
    assign pcm.sample_valid = valid_q;

`ifdef PDM_LEVEL_METER_EN
    logic [10:0]      win_cnt;
    logic [OUT_W-2:0] peak, mag, peak_nxt;
    logic [OUT_W-1:0] neg;
    logic [3:0]       lvl_nxt;

    // |sample| with the most negative value folded onto the positive maximum.
    always_comb begin
        neg = -sat_val;
        mag = sat_val[OUT_W-2:0];
        if (sat_val[OUT_W-1]) mag = neg[OUT_W-1] ? '1 : neg[OUT_W-2:0];
        peak_nxt = (mag > peak) ? mag : peak;
        lvl_nxt  = 4'd0;
        for (int i = 11; i < OUT_W - 1; i++) begin
            if (peak_nxt[i]) lvl_nxt = 4'(i - 10);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            win_cnt <= '0;
            peak    <= '0;
            level   <= 4'd0;
        end else if (loaded) begin
            win_cnt <= win_cnt + 1'b1;
            if (&win_cnt) begin
                level <= lvl_nxt;
                peak  <= '0;
            end else begin
                peak  <= peak_nxt;
            end
        end
    end
`else
    assign level = 4'd0;
`endif
endmodule

// File: tb/tb_pdm_mic_rx.sv
module tb_pdm_mic_rx;
    localparam int DECIM  = 64;
    localparam int WARMUP = 3;
    localparam int HLEN   = 3 * (DECIM - 1) + 1;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN, mic_en, M_DATA, overrun_clr;
    logic       M_CLK, M_LRSEL, overrun;
    logic [3:0] level;

    pdm_mic_rx_if #(.OUT_W(16)) pcm_if ();

    pdm_mic_rx dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .mic_en     (mic_en),
        .M_DATA     (M_DATA),
        .M_CLK      (M_CLK),
        .M_LRSEL    (M_LRSEL),
        .pcm        (pcm_if),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .level      (level)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mode = 1;          // 0: all zeros, 1: all ones, 2: alternating, 3: random
    int chk_stream = 0;
    int hist[$];           // +/-1 bits captured since the current enable
    int exp_q[$];          // expected PCM samples, in delivery order
    int h[HLEN];           // CIC impulse response: three length-DECIM boxcars convolved
    int xfer_cnt = 0;
    int last_val = 0, last_t = 0, prev_t = 0;
    bit alt_ph = 1'b0;
    bit mclk_d = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Reference: decimated output = (impulse response . last HLEN bits) >>> 3, saturated.
    task automatic model_bit(input logic b);
        int acc, n, y;
        hist.push_back(b ? 1 : -1);
        n = hist.size();
        if (n % DECIM == 0 && n / DECIM > WARMUP) begin
            acc = 0;
            for (int j = 0; j < HLEN; j++) acc += h[j] * hist[n - 1 - j];
            y = acc >>> 3;
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            if (chk_stream != 0) exp_q.push_back(y);
        end
    endtask

    task automatic wait_xfers(input int target, input int budget, input string tag);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, int'(xfer_cnt >= target), 1);
    endtask

    initial forever begin
        @(posedge CLK100MHZ);
        cyc++;
    end

    // Microphone model: new bit on each M_CLK rise, bit recorded on each capturing fall.
    initial forever begin
        @(negedge CLK100MHZ);
        if (!mic_en || !CPU_RESETN) begin
            hist.delete();
        end else if (M_CLK && !mclk_d) begin
            case (mode)
                0: M_DATA = 1'b0;
                1: M_DATA = 1'b1;
                2: begin alt_ph = ~alt_ph; M_DATA = alt_ph; end
                default: M_DATA = 1'($urandom_range(0, 1));
            endcase
        end else if (!M_CLK && mclk_d) begin
            model_bit(M_DATA);
        end
        mclk_d = M_CLK;
    end

    // Consumer side: every transfer is compared with the next expected sample.
    initial forever begin
        @(negedge CLK100MHZ);
        if (pcm_if.sample_valid === 1'b1 && pcm_if.sample_ready === 1'b1) begin
            xfer_cnt++;
            prev_t   = last_t;
            last_t   = cyc;
            last_val = pcm_if.sample;
            if (chk_stream != 0) begin
                check("stream_sample_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("stream_sample", last_val, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n, seen, bad, t_en, x0, x1, dt;
        CPU_RESETN = 1'b0; mic_en = 1'b0; M_DATA = 1'b0; overrun_clr = 1'b0;
        pcm_if.sample_ready = 1'b0;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        for (int a = 0; a < DECIM; a++)
            for (int b = 0; b < DECIM; b++)
                for (int c = 0; c < DECIM; c++) h[a + b + c]++;

        // Reset / idle
        repeat (5) step();
        CPU_RESETN = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (M_CLK !== 1'b0 || pcm_if.sample_valid !== 1'b0) seen++;
        end
        check("idle_activity", seen, 0);
        check("idle_mclk", M_CLK, 0);
        check("idle_valid", pcm_if.sample_valid, 0);
        check("idle_overrun", overrun, 0);
        check("idle_sample", pcm_if.sample, 0);
        check("idle_level", level, 0);
        check("idle_lrsel", M_LRSEL, 0);

        // Mic clock rate and duty
        mic_en = 1'b1;
        n = 0;
        do begin step(); n++; end while (!M_CLK && n < 200);
        check("mclk_first_rise", n, 20);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin step(); n++; end while (M_CLK && n < 200);
            check("mclk_high_cycles", n, 20);
            n = 0;
            do begin step(); n++; end while (!M_CLK && n < 200);
            check("mclk_low_cycles", n, 20);
        end
        mic_en = 1'b0;
        step();
        check("mclk_off_after_disable", M_CLK, 0);
        repeat (5) step();

        // Streaming: full scale, negative full scale, silence, random
        chk_stream = 1; mode = 1; pcm_if.sample_ready = 1'b1;
        x0 = xfer_cnt; t_en = cyc; mic_en = 1'b1;
        wait_xfers(x0 + 1, 11000, "fs_first_valid");
        dt = last_t - t_en;
        check("fs_first_latency_ok", int'(dt >= 10240 && dt <= 10250), 1);
        wait_xfers(x0 + 2, 3000, "fs_second_valid");
        check("fs_pos_value", last_val, 32767);
        check("fs_spacing", last_t - prev_t, 2560);
        mode = 0;
        wait_xfers(x0 + 5, 8200, "fs_neg_valid");
        check("fs_neg_value", last_val, -32768);
        mode = 2;
        wait_xfers(x0 + 8, 8200, "silence_valid");
        check("silence_value", last_val, 0);
        wait_xfers(x0 + 9, 3000, "silence_valid2");
        check("silence_value2", last_val, 0);
        mode = 3;
        wait_xfers(x0 + 12, 8200, "random_valid");
        repeat (10) step();
        check("stream_all_delivered", exp_q.size(), 0);

        // Disable halfway through a block, then re-enable
        n = 0;
        while (!(hist.size() % DECIM == DECIM / 2 && M_CLK) && n < 3000) begin step(); n++; end
        check("midop_reached_half_block", int'(hist.size() % DECIM), DECIM / 2);
        check("midop_mclk_high_before", M_CLK, 1);
        x1 = xfer_cnt;
        mic_en = 1'b0;
        step();
        check("midop_mclk_off", M_CLK, 0);
        repeat (3000) step();
        check("midop_no_new_sample", xfer_cnt, x1);
        check("midop_valid_low", pcm_if.sample_valid, 0);
        mode = 1; t_en = cyc; mic_en = 1'b1;
        wait_xfers(x1 + 1, 11000, "reen_first_valid");
        dt = last_t - t_en;
        check("reen_warmup_latency_ok", int'(dt >= 10240 && dt <= 10250), 1);
        check("reen_value", last_val, 32767);

        // Backpressure
        pcm_if.sample_ready = 1'b0; chk_stream = 0;
        n = 0;
        while (pcm_if.sample_valid !== 1'b1 && n < 3000) begin step(); n++; end
        check("bp_loaded", pcm_if.sample_valid, 1);
        bad = 0;
        repeat (3 * 2560) begin
            step();
            if (pcm_if.sample_valid !== 1'b1 || pcm_if.sample !== 16'sd32767) bad++;
        end
        repeat (100) step();
        check("bp_hold_errors", bad, 0);
        check("bp_valid_held", pcm_if.sample_valid, 1);
        check("bp_sample_held", pcm_if.sample, 32767);
        check("bp_overrun_set", overrun, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("bp_overrun_cleared", overrun, 0);
        x1 = xfer_cnt;
        pcm_if.sample_ready = 1'b1;
        step();
        pcm_if.sample_ready = 1'b0;
        check("bp_single_transfer", xfer_cnt, x1 + 1);
        check("bp_valid_after_xfer", pcm_if.sample_valid, 0);

        // Clear held high while a new overrun happens: the event must still show
        overrun_clr = 1'b1;
        seen = 0; n = 0;
        while (seen == 0 && n < 5400) begin
            step();
            n++;
            if (overrun === 1'b1) seen = 1;
        end
        overrun_clr = 1'b0;
        check("ovr_set_beats_clr", seen, 1);
        step();
        check("ovr_sticky_after_clr_release", overrun, 1);

        // Asynchronous reset in the middle of a block
        n = 0;
        while (!M_CLK && n < 50) begin step(); n++; end
        check("rst_pre_mclk_high", M_CLK, 1);
        check("rst_pre_valid", pcm_if.sample_valid, 1);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("rst_mclk", M_CLK, 0);
        check("rst_valid", pcm_if.sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sample", pcm_if.sample, 0);
        check("rst_level", level, 0);
        step();
        mic_en = 1'b0;
        CPU_RESETN = 1'b1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
